// File: rtl/fir_stream_ctrl.sv
// Sequencing controller for the shared fir_core datapath: feeds one sample at a time,
// waits out the FIR pipeline latency and queues results in a 2-entry output FIFO.
module fir_stream_ctrl #(
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic [7:0]  fir_x,
    output logic        fir_x_vld,
    input  logic [15:0] fir_y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        busy,
    output logic [15:0] sample_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_WAIT,
        S_CAPTURE
    } state_e;

    localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("fir_stream_ctrl: LATENCY must be in 1..15");
    end
    if (FIFO_DEPTH != 2) begin : g_bad_depth
        $error("fir_stream_ctrl: FIFO_DEPTH must be 2");
    end

    state_e      state_q, state_d;
    logic [7:0]  fir_x_q, fir_x_d;
    logic        fir_x_vld_q, fir_x_vld_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] sample_cnt_q, sample_cnt_d;

    logic [15:0] mem_q [2];
    logic [15:0] mem_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  fifo_count_q, fifo_count_d;

    logic        push;
    logic        pop;

    // ---------------------------------------------------------------- control
    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        fir_x_d      = fir_x_q;
        fir_x_vld_d  = 1'b0;
        wait_cnt_d   = wait_cnt_q;
        sample_cnt_d = sample_cnt_q;
        push         = 1'b0;
        in_ready     = (state_q == S_IDLE) && (fifo_count_q < 2'(FIFO_DEPTH));

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    fir_x_d     = in_data;
                    wait_cnt_d  = WAIT_INIT;
                    fir_x_vld_d = 1'b1;
                    state_d     = S_FEED;
                end
            end
            S_FEED: begin
                if (LATENCY == 1) begin
                    state_d = S_CAPTURE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q == 4'd1) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                push         = 1'b1;
                sample_cnt_d = sample_cnt_q + 16'd1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------ output FIFO
    // Acceptance is gated on a non-full FIFO, so a push always finds a free slot.
    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;
        pop          = out_valid && out_ready;

        if (push) begin
            mem_d[wr_ptr_q] = fir_y;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + 2'd1;
            2'b01:   fifo_count_d = fifo_count_q - 2'd1;
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            fir_x_q      <= 8'h00;
            fir_x_vld_q  <= 1'b0;
            wait_cnt_q   <= 4'd0;
            sample_cnt_q <= 16'h0000;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            fifo_count_q <= 2'd0;
            // NOTE: the two storage words are reset on purpose so an empty FIFO
            // presents 0x0000 on out_data after reset rather than stale data.
            mem_q[0]     <= 16'h0000;
            mem_q[1]     <= 16'h0000;
        end else begin
            state_q      <= state_d;
            fir_x_q      <= fir_x_d;
            fir_x_vld_q  <= fir_x_vld_d;
            wait_cnt_q   <= wait_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
            mem_q        <= mem_d;
        end
    end

    assign fir_x      = fir_x_q;
    assign fir_x_vld  = fir_x_vld_q;
    assign busy       = (state_q != S_IDLE);
    assign sample_cnt = sample_cnt_q;
    assign out_valid  = (fifo_count_q != 2'd0);
    assign out_data   = mem_q[rd_ptr_q];

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        push |-> (fifo_count_q != 2'd2 || pop));

endmodule

// File: doc/fir_stream_ctrl.md
# fir_stream_ctrl

Sequencing controller for the shared `fir_core` FIR datapath. It accepts 8-bit input samples over a valid/ready handshake and drives each one into the FIR as a single-cycle strobe. It waits a fixed pipeline latency, captures the 16-bit result into a 2-entry output FIFO, and presents results over a valid/ready handshake. It sits between the pin-level wrapper and `fir_core`, so upstream logic never has to track FIR latency or stall behaviour.

## Interface
- `LATENCY`, 4: cycles from the `fir_x_vld` strobe to a valid `fir_y`; legal range 1–15.
- `FIFO_DEPTH`, 2: output FIFO entries; fixed at 2.
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: upstream sample valid.
- `in_ready` out 1: controller can accept a sample.
- `in_data` in 8: input sample.
- `fir_x` out 8: sample driven to `fir_core` `x_rsc_dat`; registered.
- `fir_x_vld` out 1: one-cycle strobe marking a new `fir_x`.
- `fir_y` in 16: `fir_core` `y_rsc_dat`.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: downstream accepts the head.
- `out_data` out 16: FIFO head data.
- `busy` out 1: a sample is in flight (state is not IDLE).
- `sample_cnt` out 16: number of results captured; wraps from 0xFFFF to 0x0000.

## Operation
- States: IDLE, FEED, WAIT, CAPTURE.
- IDLE:
  - `in_ready` = (`fifo_count` < 2).
  - On `in_valid && in_ready`: `fir_x` <= `in_data`, `wait_cnt` <= LATENCY-1, go to FEED.
- FEED (1 cycle):
  - `fir_x_vld` = 1.
  - Go to WAIT, or go directly to CAPTURE when LATENCY = 1.
- WAIT:
  - Decrement `wait_cnt` each cycle.
  - When `wait_cnt` = 1, go to CAPTURE.
- CAPTURE (1 cycle):
  - Push `fir_y` into the FIFO.
  - `sample_cnt` <= `sample_cnt` + 1.
  - Go to IDLE.
- At most one sample is in flight.
- Acceptance requires `fifo_count` < 2 at the accept cycle, so a CAPTURE always has room. A push never overflows; no overflow path exists.
- FIFO:
  - 2 entries, read/write pointers plus a 2-bit count.
  - Pop on `out_valid && out_ready`.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - A pop in the CAPTURE cycle with count 2 leaves count 2.
- `in_ready` is combinational from state and `fifo_count` only. It never depends on `in_valid`.
- `out_valid` = (`fifo_count` != 0). `out_data` = entry at the read pointer.
- `fir_x` holds its last value outside accepts, because the FIR sees `x` continuously.
- Arithmetic: the only counters are the unsigned `sample_cnt` (modulo 2^16) and `wait_cnt` (4 bits). `fir_y` is stored unmodified.

## Timing
- Reset values, applied at the first rising edge with `rst` = 1:
  - state IDLE; `fir_x` 0x00; `fir_x_vld` 0; `wait_cnt` 0.
  - FIFO empty: `out_valid` 0, `out_data` 0x0000.
  - `sample_cnt` 0x0000; `busy` 0; `in_ready` 1 from the first cycle after reset deasserts.
- Reset mid-operation:
  - Drops the in-flight sample and flushes the FIFO.
  - No CAPTURE occurs for a sample accepted before reset.
- Accept at edge T:
  - `fir_x_vld` high during cycle T+1.
  - `fir_y` sampled at edge T+1+LATENCY.
  - `out_valid` high from cycle T+2+LATENCY if the FIFO was empty.
  - `in_ready` high again at T+2+LATENCY if count < 2.
- Throughput: one sample per LATENCY+2 cycles with `out_ready` held at 1.
- `busy` is high from T+1 through the CAPTURE cycle inclusive.
- Downstream stall:
  - After 2 captures without a pop, `in_ready` stays 0 until a pop.
  - The first accept can occur in the same cycle the pop brings the count to 1. `in_ready` follows the registered count, so it rises the cycle after the pop.
- Data ordering: results leave in input order.

## Test plan
- Reset then single sample: `in_data` = 0x05, `fir_y` model = 3·x, LATENCY 4, `out_ready` = 1 → `fir_x_vld` one cycle at T+1, `out_data` = 0x000F valid at T+6, `sample_cnt` = 1.
- Back-to-back stream: 0x01–0x08 with `in_valid` held and `out_ready` = 1 → accepts exactly every 6 cycles; 8 results in order; `sample_cnt` = 8.
- Backpressure: `out_ready` = 0, offer 3 samples → 2 captured, `in_ready` = 0. Raise `out_ready` for 1 cycle → head popped, third sample accepted next cycle, order intact.
- Simultaneous push/pop: FIFO count 1 with `out_ready` = 1 during CAPTURE → count stays 1 and the next head is the new result.
- Reset mid-flight: assert `rst` in WAIT with 1 entry in the FIFO → next cycle `out_valid` 0, `busy` 0, `fir_x` 0x00, `sample_cnt` 0, and no later capture.
- Wrap and LATENCY = 1 build: preload `sample_cnt` via 65 535 captures (or force) → next capture gives 0x0000; LATENCY 1 gives `out_valid` at T+3.
